// File: rtl/m_serial_shifter_pkg.sv
// Package m_shift_pkg: shared definitions for the serial shifter slice.
//   sh_op_e   : request opcode encodings (2'b11 is reserved and behaves as SLL)
//   state_e   : controller states
//   CNT_*     : shift down-counter modes, encoded as {sa18, sa19}
package m_shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] CNT_LOAD = 2'b00;
  localparam logic [1:0] CNT_DOWN = 2'b10;
  localparam logic [1:0] CNT_HOLD = 2'b11;

endpackage

// File: rtl/m_serial_shifter_if.sv
// Interface m_serial_shifter_if: request and result handshakes of the serial shifter.
//   req_valid/req_ready/req_op/req_a/req_shamt : request channel
//   res_valid/res_ready/res_data               : result channel
//   master : requester side, slave : shifter side
interface m_serial_shifter_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [4:0]      req_shamt;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;

  modport master (
    output req_valid, req_op, req_a, req_shamt, res_ready,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_shamt, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/m_serial_shifter_datareg.sv
// Module m_shift_datareg: XLEN-wide operand/result register for the serial shifter.
//   clk, rst     : clock, asynchronous active-high reset (clears to 0)
//   load_i, a_i  : load operand (has priority over shifting)
//   shift_i      : shift one bit this cycle
//   dir_right_i  : 1 = shift right, 0 = shift left (fill 0)
//   arith_i      : right shifts fill with the current msb instead of 0
//   q_o          : register contents
module m_shift_datareg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] a_i,
  input  logic            shift_i,
  input  logic            dir_right_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = a_i;
    end else if (shift_i) begin
      if (dir_right_i) begin
        data_d = {arith_i & data_q[XLEN-1], data_q[XLEN-1:1]};
      end else begin
        data_d = {data_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/m_serial_shifter.sv
// Module m_serial_shifter: one-bit-per-cycle SLL/SRL/SRA unit driving an external
// 5-bit shift down-counter.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : m_serial_shifter_if.slave (request and result handshakes)
//   sa18, sa19  : counter mode {sa18,sa19}: 00 load, 10 count down, 11 hold
//   cnt_b       : counter load value (captured shift amount)
//   lastshift   : counter is at zero; only looked at in SHIFT
// Build option: M_SERIAL_SHIFTER_ZERO_BYPASS_EN sends shamt=0 straight from LOAD
// to DONE instead of spending a SHIFT cycle waiting for lastshift.
//
// state    | meaning
// ST_IDLE  | ready for a request, counter held
// ST_LOAD  | counter loaded with shamt, no data movement
// ST_SHIFT | counter counts down, one data shift per cycle until lastshift
// ST_DONE  | result presented, waiting for res_ready
module m_serial_shifter
  import m_shift_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  m_serial_shifter_if.slave    bus,
  output logic                 sa18,
  output logic                 sa19,
  output logic [4:0]           cnt_b,
  input  logic                 lastshift
);

  state_e     state_q;
  logic [1:0] op_q;
  logic [1:0] cnt_mode_q;
  logic [4:0] cnt_b_q;
  logic       req_ready_q;
  logic       res_valid_q;

  logic            accept;
  logic            do_shift;
  logic [XLEN-1:0] data;

  assign accept   = (state_q == ST_IDLE) && bus.req_valid;
  // The terminal cycle (lastshift=1) is spent in SHIFT but moves no data.
  assign do_shift = (state_q == ST_SHIFT) && !lastshift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      cnt_mode_q  <= CNT_HOLD;
      cnt_b_q     <= 5'd0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            cnt_b_q     <= bus.req_shamt;
            cnt_mode_q  <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
`ifdef M_SERIAL_SHIFTER_ZERO_BYPASS_EN
          if (cnt_b_q == 5'd0) begin
            cnt_mode_q  <= CNT_HOLD;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_mode_q <= CNT_DOWN;
            state_q    <= ST_SHIFT;
          end
`else
          cnt_mode_q <= CNT_DOWN;
          state_q    <= ST_SHIFT;
`endif
        end
        ST_SHIFT: begin
          if (lastshift) begin
            cnt_mode_q  <= CNT_HOLD;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  m_shift_datareg #(.XLEN(XLEN)) u_datareg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .a_i         (bus.req_a),
    .shift_i     (do_shift),
    .dir_right_i ((op_q == SH_SRL) || (op_q == SH_SRA)),
    .arith_i     (op_q == SH_SRA),
    .q_o         (data)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = data;
  assign sa18          = cnt_mode_q[1];
  assign sa19          = cnt_mode_q[0];
  assign cnt_b         = cnt_b_q;

endmodule

// File: tb/tb_m_serial_shifter.sv
// Testbench for m_serial_shifter: random and directed shifts checked against
// plain-arithmetic shift results, with a behavioural 5-bit down-counter that
// follows sa18/sa19/cnt_b and produces lastshift.
module tb_m_serial_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sa18, sa19, lastshift;
  logic [4:0] cnt_b;
  logic [4:0] cnt_m;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  m_serial_shifter_if #(.XLEN(32)) bus ();

  m_serial_shifter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sa18      (sa18),
    .sa19      (sa19),
    .cnt_b     (cnt_b),
    .lastshift (lastshift)
  );

  // Counter: 00 load B, 10 count down (stops at zero), 11 hold.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_m <= 5'd0;
    else if ({sa18, sa19} == 2'b00) cnt_m <= cnt_b;
    else if ({sa18, sa19} == 2'b10 && cnt_m != 5'd0) cnt_m <= cnt_m - 5'd1;
  end
  assign lastshift = (cnt_m == 5'd0);

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] a, logic [4:0] sh);
    case (op)
      2'b01:   return a >> sh;
      2'b10:   return $signed(a) >>> sh;
      default: return a << sh;
    endcase
  endfunction

  function automatic int ref_lat(logic [4:0] sh);
`ifdef M_SERIAL_SHIFTER_ZERO_BYPASS_EN
    if (sh == 5'd0) return 1;
`endif
    return int'(sh) + 2;
  endfunction

  // Present a request and let it be taken on the next edge; afterwards the
  // request inputs are scrambled since the design must not depend on them.
  task automatic start_req(logic [1:0] op, logic [31:0] a, logic [4:0] sh);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_shamt = sh;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_a     = $urandom;
    bus.req_shamt = 5'($urandom);
  endtask

  // Cycles from the accepting edge until res_valid is seen; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (bus.res_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = '0;
    bus.req_shamt = 5'd0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", bus.req_ready); else n_pass++;
    n_total++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", bus.res_valid); else n_pass++;
    n_total++; if (bus.res_data !== 32'h0) $display("FAIL reset_res_data got %h want 0", bus.res_data); else n_pass++;
    n_total++; if ({sa18, sa19} !== 2'b11) $display("FAIL reset_sa got %b want 11", {sa18, sa19}); else n_pass++;
    n_total++; if (cnt_b !== 5'd0) $display("FAIL reset_cnt_b got %0d want 0", cnt_b); else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
  } vec_t;

  task automatic run_one(string name, logic [1:0] op, logic [31:0] a, logic [4:0] sh);
    int lat;
    logic [31:0] exp_d;
    exp_d = ref_shift(op, a, sh);
    start_req(op, a, sh);
    wait_result(lat);
    n_total++; if (lat !== ref_lat(sh)) $display("FAIL %s_latency got %0d want %0d", name, lat, ref_lat(sh)); else n_pass++;
    n_total++; if (bus.res_data !== exp_d) $display("FAIL %s_data op=%0d a=%h sh=%0d got %h want %h", name, op, a, sh, bus.res_data, exp_d); else n_pass++;
    n_total++; if (bus.req_ready !== 1'b0 || {sa18, sa19} !== 2'b11) $display("FAIL %s_done_ctrl got ready=%b sa=%b want 0/11", name, bus.req_ready, {sa18, sa19}); else n_pass++;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    take_result();
    n_total++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL %s_release got valid=%b ready=%b want 0/1", name, bus.res_valid, bus.req_ready); else n_pass++;
  endtask

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{2'b00, 32'h0000_0001, 5'd4});
    v.push_back('{2'b10, 32'h8000_0000, 5'd31});
    v.push_back('{2'b01, 32'h8000_0000, 5'd31});
    v.push_back('{2'b00, 32'hDEAD_BEEF, 5'd0});
    v.push_back('{2'b01, 32'hDEAD_BEEF, 5'd0});
    v.push_back('{2'b10, 32'hDEAD_BEEF, 5'd0});
    v.push_back('{2'b11, 32'hDEAD_BEEF, 5'd0});
    v.push_back('{2'b11, 32'h1234_5678, 5'd8});
    v.push_back('{2'b10, 32'h7FFF_FFF0, 5'd3});
    foreach (v[i]) run_one("directed", v[i].op, v[i].a, v[i].sh);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_one("random", 2'($urandom), $urandom, 5'($urandom));
  endtask

  task automatic test_hold();
    int lat;
    logic [31:0] exp_d;
    exp_d = ref_shift(2'b01, 32'hF0F0_1234, 5'd7);
    start_req(2'b01, 32'hF0F0_1234, 5'd7);
    wait_result(lat);
    n_total++; if (lat !== ref_lat(5'd7)) $display("FAIL hold_latency got %0d want %0d", lat, ref_lat(5'd7)); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = 1'b1;
      bus.req_a     = $urandom;
      bus.req_shamt = 5'($urandom);
      @(posedge clk); #1;
      n_total++; if (bus.res_valid !== 1'b1 || bus.req_ready !== 1'b0) $display("FAIL hold_handshake got valid=%b ready=%b want 1/0", bus.res_valid, bus.req_ready); else n_pass++;
      n_total++; if (bus.res_data !== exp_d) $display("FAIL hold_data got %h want %h", bus.res_data, exp_d); else n_pass++;
    end
    bus.req_valid = 1'b0;
    take_result();
    @(posedge clk); #1;
    n_total++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) $display("FAIL hold_no_accept got ready=%b valid=%b want 1/0", bus.req_ready, bus.res_valid); else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit seen;
    start_req(2'b00, 32'hA5A5_A5A5, 5'd20);
    repeat (6) @(posedge clk);
    #1;
    n_total++; if (bus.res_valid !== 1'b0) $display("FAIL rst_mid_early_valid got %b want 0", bus.res_valid); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) $display("FAIL rst_mid_idle got ready=%b valid=%b want 1/0", bus.req_ready, bus.res_valid); else n_pass++;
    n_total++; if ({sa18, sa19} !== 2'b11) $display("FAIL rst_mid_sa got %b want 11", {sa18, sa19}); else n_pass++;
    n_total++; if (bus.res_data !== 32'h0) $display("FAIL rst_mid_data got %h want 0", bus.res_data); else n_pass++;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rst_mid_stale_result got %b want 0", seen); else n_pass++;
    run_one("after_rst", 2'b10, 32'h8000_0F00, 5'd5);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp2;
    exp2 = ref_shift(2'b10, 32'h9000_0001, 5'd6);
    start_req(2'b00, 32'h0000_00FF, 5'd3);
    wait_result(lat);
    n_total++; if (bus.res_data !== 32'h0000_07F8) $display("FAIL b2b_first_data got %h want 000007f8", bus.res_data); else n_pass++;
    bus.res_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_a     = 32'h9000_0001;
    bus.req_shamt = 5'd6;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    n_total++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL b2b_exit got valid=%b ready=%b want 0/1", bus.res_valid, bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_total++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_accept got ready=%b want 0", bus.req_ready); else n_pass++;
    wait_result(lat);
    n_total++; if (lat !== ref_lat(5'd6)) $display("FAIL b2b_latency got %0d want %0d", lat, ref_lat(5'd6)); else n_pass++;
    n_total++; if (bus.res_data !== exp2) $display("FAIL b2b_second_data got %h want %h", bus.res_data, exp2); else n_pass++;
    take_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
